// File: rtl/pdm_player_pkg.sv
// Shared definitions for the PDM playback and capture paths: FSM states,
// ctrl bit positions and the default run length.
package pdm_player_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        PLAY = 2'd2
    } state_t;

    localparam int CTRL_START    = 0;
    localparam int CTRL_CLR      = 1;
    localparam int DEFAULT_BOUND = 46875;
    localparam int WORD_W        = 32;

endpackage

// File: rtl/pdm_serializer.sv
// MSB-first shifter for packed PDM words with a one-word prefetch buffer.
// bitcnt reaching zero (last_bit) tells the controller a reload is due.
module pdm_serializer
    import pdm_player_pkg::*;
(
    input  logic              clk,
    input  logic              clear,
    input  logic              load_first,
    input  logic              load,
    input  logic              capture,
    input  logic              shift,
    input  logic [WORD_W-1:0] rdata,
    output logic              msb,
    output logic              last_bit,
    output logic              nxt_vld
);

    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] nxt;
    logic [4:0]        bitcnt;

    assign msb      = shreg[WORD_W-1];
    assign last_bit = (bitcnt == 5'd0);

    // The prefetched word lands in nxt long before it is needed at the reload.
    always_ff @(posedge clk) begin
        if (clear) begin
            shreg   <= '0;
            bitcnt  <= '0;
            nxt_vld <= 1'b0;
        end else begin
            if (load_first) begin
                shreg   <= rdata;
                bitcnt  <= 5'd31;
                nxt_vld <= 1'b0;
            end else if (load) begin
                shreg   <= nxt;
                bitcnt  <= 5'd31;
                nxt_vld <= 1'b0;
            end else if (shift) begin
                shreg  <= {shreg[WORD_W-2:0], 1'b0};
                bitcnt <= bitcnt - 5'd1;
            end
            if (capture) begin
                nxt     <= rdata;
                nxt_vld <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pdm_player.sv
// PDM playback engine: fetches BOUND packed words from sample memory and
// plays them gap-free, one bit per pdm_clk, MSB first.
module pdm_player
    import pdm_player_pkg::*;
#(
    parameter int BOUND = DEFAULT_BOUND,
    parameter int AW    = 16
) (
    input  logic          pdm_clk,
    input  logic          rst,
    input  logic [1:0]    ctrl,
    output logic          rd_en,
    output logic [AW-1:0] raddr,
    input  logic [31:0]   rdata,
    output logic          pdm_out,
    output logic [AW-1:0] didx,
    output logic          bsy,
    output logic          done
);

    localparam logic [AW:0] LAST_IDX = (AW+1)'(BOUND - 1);

    state_t      state;
    state_t      state_nxt;
    logic        rvld;
    logic        clr;
    logic        start;
    logic        msb;
    logic        last_bit;
    logic        nxt_vld;
    logic        load_first;
    logic        load;
    logic        capture;
    logic        shift;
    logic        last_word;
    logic [AW:0] pf_idx;

    assign clr       = ctrl[CTRL_CLR];
    assign start     = ctrl[CTRL_START] & ~clr;
    assign last_word = ({1'b0, didx} == LAST_IDX);
    assign pf_idx    = {1'b0, didx} + (AW+1)'(2);
    assign pdm_out   = (state == PLAY) && msb;

    // rvld marks the cycle in which rdata answers the previous rd_en.
    always_comb begin
        state_nxt  = state;
        load_first = 1'b0;
        load       = 1'b0;
        capture    = 1'b0;
        shift      = 1'b0;
        unique case (state)
            IDLE: if (start) state_nxt = FILL;
            FILL: begin
                if (rvld) begin
                    load_first = 1'b1;
                    state_nxt  = PLAY;
                end
            end
            PLAY: begin
                capture = rvld;
                shift   = 1'b1;
                if (last_bit) begin
                    if (last_word) state_nxt = IDLE;
                    else           load      = nxt_vld;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (clr) state_nxt = IDLE;
    end

    always_ff @(posedge pdm_clk) begin
        if (rst || clr) begin
            state <= IDLE;
            rd_en <= 1'b0;
            raddr <= '0;
            didx  <= '0;
            bsy   <= 1'b0;
            done  <= 1'b0;
            rvld  <= 1'b0;
        end else begin
            state <= state_nxt;
            rd_en <= 1'b0;
            done  <= 1'b0;
            rvld  <= rd_en;
            case (state)
                IDLE: begin
                    if (start) begin
                        rd_en <= 1'b1;
                        raddr <= '0;
                        bsy   <= 1'b1;
                    end
                end
                FILL: begin
                    if (rvld) begin
                        didx <= '0;
                    end else if (BOUND > 1) begin
                        rd_en <= 1'b1;
                        raddr <= AW'(1);
                    end
                end
                PLAY: begin
                    // Reload edge doubles as the prefetch slot for two words ahead.
                    if (last_bit) begin
                        if (last_word) begin
                            bsy  <= 1'b0;
                            done <= 1'b1;
                        end else if (nxt_vld) begin
                            didx <= didx + AW'(1);
                            if (pf_idx <= LAST_IDX) begin
                                rd_en <= 1'b1;
                                raddr <= pf_idx[AW-1:0];
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    pdm_serializer u_ser (
        .clk        (pdm_clk),
        .clear      (rst | clr),
        .load_first (load_first),
        .load       (load),
        .capture    (capture),
        .shift      (shift),
        .rdata      (rdata),
        .msb        (msb),
        .last_bit   (last_bit),
        .nxt_vld    (nxt_vld)
    );

endmodule

// File: tb/tb_pdm_player.sv
// Directed bench for pdm_player: three instances (BOUND = 2, 1, 4) each
// backed by a latency-1 memory model with hand-computed expected streams.
module tb_pdm_player;

    localparam int AW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [1:0]    ctrl_a, ctrl_b, ctrl_c;
    logic          rd_en_a, rd_en_b, rd_en_c;
    logic [AW-1:0] raddr_a, raddr_b, raddr_c;
    logic [31:0]   rdata_a = '0, rdata_b = '0, rdata_c = '0;
    logic          pdm_a, pdm_b, pdm_c;
    logic [AW-1:0] didx_a, didx_b, didx_c;
    logic          bsy_a, bsy_b, bsy_c;
    logic          done_a, done_b, done_c;

    logic [31:0] mem_a [2] = '{32'hA500_0001, 32'h8000_0000};
    logic [31:0] mem_b     = 32'hFFFF_FFFF;
    logic [31:0] mem_c [4] = '{32'h0F1E_2D3C, 32'h4B5A_6978, 32'h8796_A5B4, 32'hC3D2_E1F0};

    int   reads_a = 0, reads_b = 0, reads_c = 0;
    logic bad_a = 1'b0, bad_b = 1'b0, bad_c = 1'b0;

    int tests  = 0;
    int errors = 0;

    // Trace entry layout: {rd_en, raddr[7:0], didx[7:0], pdm_out, bsy, done}
    logic [19:0]  trace [200];
    logic [127:0] stream;
    int           done_at;
    int           r0;
    logic         acc;

    pdm_player #(.BOUND(2), .AW(AW)) u_a (
        .pdm_clk(clk), .rst(rst), .ctrl(ctrl_a), .rd_en(rd_en_a), .raddr(raddr_a),
        .rdata(rdata_a), .pdm_out(pdm_a), .didx(didx_a), .bsy(bsy_a), .done(done_a)
    );
    pdm_player #(.BOUND(1), .AW(AW)) u_b (
        .pdm_clk(clk), .rst(rst), .ctrl(ctrl_b), .rd_en(rd_en_b), .raddr(raddr_b),
        .rdata(rdata_b), .pdm_out(pdm_b), .didx(didx_b), .bsy(bsy_b), .done(done_b)
    );
    pdm_player #(.BOUND(4), .AW(AW)) u_c (
        .pdm_clk(clk), .rst(rst), .ctrl(ctrl_c), .rd_en(rd_en_c), .raddr(raddr_c),
        .rdata(rdata_c), .pdm_out(pdm_c), .didx(didx_c), .bsy(bsy_c), .done(done_c)
    );

    always @(posedge clk) begin
        if (rd_en_a) begin
            rdata_a <= mem_a[raddr_a[0]];
            reads_a <= reads_a + 1;
            if (raddr_a >= AW'(2)) bad_a <= 1'b1;
        end
        if (rd_en_b) begin
            rdata_b <= mem_b;
            reads_b <= reads_b + 1;
            if (raddr_b >= AW'(1)) bad_b <= 1'b1;
        end
        if (rd_en_c) begin
            rdata_c <= mem_c[raddr_c[1:0]];
            reads_c <= reads_c + 1;
            if (raddr_c >= AW'(4)) bad_c <= 1'b1;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int which, input logic [1:0] value);
        case (which)
            0:       ctrl_a = value;
            1:       ctrl_b = value;
            default: ctrl_c = value;
        endcase
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [19:0] outs(input int which);
        case (which)
            0:       return {rd_en_a, raddr_a, didx_a, pdm_a, bsy_a, done_a};
            1:       return {rd_en_b, raddr_b, didx_b, pdm_b, bsy_b, done_b};
            default: return {rd_en_c, raddr_c, didx_c, pdm_c, bsy_c, done_c};
        endcase
    endfunction

    // One start pulse, then record every cycle until done (bounded).
    task automatic runDut(input int which, input int nbits, input bit toggle,
                          output logic [127:0] strm, output int dat);
        strm = '0;
        dat  = -1;
        for (int i = 0; i < 200; i++) trace[i] = '0;
        applyStimulus(which, 2'b01);
        for (int c = 0; c < nbits + 10 && dat < 0; c++) begin
            step;
            applyStimulus(which, (toggle && c[0]) ? 2'b01 : 2'b00);
            trace[c] = outs(which);
            if (c >= 2 && c < nbits + 2) strm = {strm[126:0], trace[c][2]};
            if (trace[c][0]) dat = c;
        end
        applyStimulus(which, 2'b00);
    endtask

    initial begin
        rst = 1'b1;
        ctrl_a = 2'b00;
        ctrl_b = 2'b00;
        ctrl_c = 2'b00;
        step;
        step;
        rst = 1'b0;
        checkOutput("reset_a", 128'(outs(0)), '0);
        checkOutput("reset_c", 128'(outs(2)), '0);

        // BOUND=2: two words, fill reads back to back, done 66 cycles after start
        r0 = reads_a;
        runDut(0, 64, 1'b0, stream, done_at);
        checkOutput("a_first_read", {trace[0][19], trace[0][18:11], trace[0][1], trace[0][2]},
                    {1'b1, 8'd0, 1'b1, 1'b0});
        checkOutput("a_second_read", {trace[1][19], trace[1][18:11]}, {1'b1, 8'd1});
        checkOutput("a_stream", stream, {64'h0, 32'hA500_0001, 32'h8000_0000});
        checkOutput("a_done_at", done_at, 66);
        checkOutput("a_done_cycle", trace[66][2:0], 3'b001);
        checkOutput("a_didx_step", {trace[33][10:3], trace[34][10:3]}, {8'd0, 8'd1});
        acc = 1'b1;
        for (int c = 0; c < 66; c++) acc &= trace[c][1];
        checkOutput("a_bsy_held", acc, 1'b1);
        step;
        checkOutput("a_done_pulse", {done_a, bsy_a}, 2'b00);
        checkOutput("a_reads", reads_a - r0, 2);

        // BOUND=1: single read, 32 ones, didx never moves
        r0 = reads_b;
        runDut(1, 32, 1'b0, stream, done_at);
        checkOutput("b_rd_pulse", {trace[0][19], trace[1][19]}, 2'b10);
        checkOutput("b_stream", stream, {96'h0, 32'hFFFF_FFFF});
        checkOutput("b_done_at", done_at, 34);
        acc = 1'b0;
        for (int c = 0; c < 35; c++) acc |= |trace[c][10:3];
        checkOutput("b_didx_zero", acc, 1'b0);
        checkOutput("b_reads", reads_b - r0, 1);

        // BOUND=4: gap-free 128 bits, didx steps at word boundaries, prefetch stops at 3
        r0 = reads_c;
        runDut(2, 128, 1'b0, stream, done_at);
        checkOutput("c_stream", stream, 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0);
        checkOutput("c_done_at", done_at, 130);
        checkOutput("c_didx", {trace[2][10:3], trace[33][10:3], trace[34][10:3], trace[65][10:3],
                               trace[66][10:3], trace[97][10:3], trace[98][10:3], trace[129][10:3]},
                    {8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3});
        checkOutput("c_prefetch", {trace[34][19:11], trace[66][19:11], trace[98][19]},
                    {1'b1, 8'd2, 1'b1, 8'd3, 1'b0});
        checkOutput("c_reads", reads_c - r0, 4);

        // Clear in the middle of word 2, then replay from word 0
        applyStimulus(2, 2'b01);
        step;
        applyStimulus(2, 2'b00);
        for (int c = 1; c <= 70; c++) step;
        applyStimulus(2, 2'b10);
        step;
        applyStimulus(2, 2'b00);
        checkOutput("c_clear_outs", 128'(outs(2)), '0);
        acc = 1'b0;
        for (int c = 0; c < 140; c++) begin
            step;
            acc |= done_c | bsy_c;
        end
        checkOutput("c_clear_no_done", acc, 1'b0);
        r0 = reads_c;
        runDut(2, 128, 1'b0, stream, done_at);
        checkOutput("c_replay_stream", stream, 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0);
        checkOutput("c_replay_done_at", done_at, 130);
        checkOutput("c_replay_reads", reads_c - r0, 4);

        // Start held high: runs separated by exactly one IDLE cycle
        applyStimulus(1, 2'b01);
        for (int c = 0; c < 76; c++) begin
            step;
            trace[c] = outs(1);
        end
        applyStimulus(1, 2'b10);
        step;
        applyStimulus(1, 2'b00);
        step;
        checkOutput("b_held_restart", {trace[34][0], trace[34][1], trace[35][1], trace[35][19],
                                       trace[68][0], trace[69][0]}, 6'b101101);
        checkOutput("b_held_cleared", 128'(outs(1)), '0);

        // Start toggling while busy is ignored
        r0 = reads_a;
        runDut(0, 64, 1'b1, stream, done_at);
        checkOutput("a_toggle_stream", stream, {64'h0, 32'hA500_0001, 32'h8000_0000});
        checkOutput("a_toggle_done_at", done_at, 66);
        checkOutput("a_toggle_reads", reads_a - r0, 2);

        // Reset during PLAY
        applyStimulus(2, 2'b01);
        step;
        applyStimulus(2, 2'b00);
        for (int c = 1; c <= 40; c++) step;
        checkOutput("c_playing", bsy_c, 1'b1);
        rst = 1'b1;
        step;
        checkOutput("c_rst_outs", 128'(outs(2)), '0);
        rst = 1'b0;
        step;
        checkOutput("c_rst_idle", 128'(outs(2)), '0);

        checkOutput("no_oob_reads", {bad_a, bad_b, bad_c}, 3'b000);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/pdm_player.md
# pdm_player

PDM playback engine, the transmit counterpart of the PDM capture path. It reads packed 32-bit PDM words from the sample memory by word index and serializes them MSB-first onto a 1-bit PDM output, one bit per `pdm_clk`. A one-word prefetch buffer keeps the bitstream gap-free across word boundaries. Software controls it through the same 2-bit `ctrl` convention as capture: bit 0 starts playback, bit 1 clears.

## Interface
- `BOUND`, default 46875: number of 32-bit words played per run (indices 0..BOUND-1); must be ≥1.
- `AW`, default 16: memory word-address width.
- `pdm_clk`  in  1  sole clock; one PDM bit per cycle.
- `rst`  in  1  synchronous, active-high reset.
- `ctrl`  in  2  [0] start (level, sampled in IDLE); [1] clear/abort (highest priority).
- `rd_en`  out  1  memory read strobe, registered, one cycle per word.
- `raddr`  out  AW  memory word address, registered; valid while `rd_en`=1.
- `rdata`  in  32  memory read data; valid exactly one cycle after the `rd_en` cycle (fixed latency 1).
- `pdm_out`  out  1  serialized PDM bitstream.
- `didx`  out  AW  index of the word currently on `pdm_out`.
- `bsy`  out  1  high from start acceptance until the last bit has been sent.
- `done`  out  1  one-cycle pulse after the last bit of word BOUND-1.

## Operation
- States: IDLE, FILL, PLAY.
- IDLE: `pdm_out`=0, `bsy`=0. If `ctrl[0]`=1 and `ctrl[1]`=0 at a clock edge: go to FILL, `rd_en`<=1, `raddr`<=0, `bsy`<=1.
- FILL: wait for word 0. On the edge where `rdata` is valid, `shreg`<=`rdata`, `bitcnt`<=31, `didx`<=0, go to PLAY. If BOUND>1, the read of word 1 has already been issued on the cycle after the word-0 read, so `rd_en` is high for two consecutive cycles.
- PLAY:
  - `pdm_out`=`shreg[31]`; each cycle `shreg` shifts left by one and `bitcnt` decrements.
  - The returned `rdata` is captured into `nxt` and `nxt_vld` is set.
  - When `bitcnt`=0 and the current word is not the last: `shreg`<=`nxt`, `nxt_vld`<=0, `bitcnt`<=31, `didx`<=`didx`+1.
  - On that same reload edge, if `didx`+2 ≤ BOUND-1, the next prefetch is issued (`rd_en`<=1, `raddr`<=`didx`+2).
- End of run: at `bitcnt`=0 with `didx`=BOUND-1, go to IDLE, `bsy`<=0, `done`<=1 for one cycle, `pdm_out` returns to 0. No read is ever issued for an address ≥ BOUND.
- `ctrl[1]`=1 (any state): next edge forces IDLE and clears `rd_en`, `raddr`, `didx`, `shreg`, `nxt_vld`, `bitcnt`, `bsy` and `pdm_out` to 0; no `done` pulse. An in-flight `rdata` is discarded.
- `ctrl[0]` while `bsy`=1 is ignored. `ctrl[0]` held high after `done` restarts playback from IDLE on the following edge.
- Arithmetic: `didx` and `raddr` are AW bits and never wrap, because they stop at BOUND-1. `bitcnt` is 5 bits.

## Timing
- Reset values: `rd_en`=0, `raddr`=0, `didx`=0, `pdm_out`=0, `bsy`=0, `done`=0; state IDLE.
- Start accepted at edge E0:
  - `rd_en`=1 with `raddr`=0 during E0–E1.
  - `rdata` (word 0) valid during E1–E2.
  - Word-0 bit 31 appears on `pdm_out` after E2.
  - Start-to-first-bit latency: 2 cycles.
- Bits are back-to-back: word k bit 0 is followed directly by word k+1 bit 31.
- Prefetch margin: 30 cycles, so `nxt_vld` is always 1 at reload.
- A run occupies 2 + 32·BOUND cycles of `bsy`=1. `done` is high during the cycle after the last bit.
- `rd_en` pulses are always one cycle wide, except for the back-to-back pair in FILL.

## Structure
- Shared package/include: state encodings (IDLE, FILL, PLAY), `ctrl` bit positions (`CTRL_START`=0, `CTRL_CLR`=1) and the default BOUND. These are shared with the capture block's parameter include.
- One natural sub-module: `pdm_serializer`, which holds the 32-bit shift register, `bitcnt`, the `nxt` buffer and the `load`/`last_bit` handshake. `pdm_player` keeps the FSM and the address/index logic.

## Test plan
- BOUND=2, memory words 0xA5000001 and 0x80000000, pulse `ctrl[0]` → `pdm_out` carries 1010_0101, 0…0, 1, then 1, 0…0; `done` pulses at cycle 66 after start; exactly 2 reads (addresses 0 and 1).
- BOUND=1, word 0xFFFFFFFF → 32 ones starting 2 cycles after start; a single `rd_en` pulse; `didx` stays 0.
- BOUND=4, incrementing pattern → continuous 128-bit stream with no idle bit at boundaries; `didx` steps 0→3 at bit-31 times; no `raddr` ≥ 4.
- Assert `ctrl[1]` mid-word 2 → next cycle all outputs are 0, no `done`; a new start replays from word 0.
- `ctrl[0]` held high throughout → back-to-back runs separated by one IDLE cycle; toggling `ctrl[0]` while busy has no effect.
- `rst` asserted during PLAY → all outputs at their reset values on the next edge.
